// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and EX/WB load/store.
// Data accesses win over fetches; an issued fetch is never preempted.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_pipe,
  output logic              stall_if,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    D_BUSY,
    D_DONE,
    F_BUSY,
    F_DONE
  } state_t;

  state_t state, state_next;
  logic   d_op;

  assign d_op = d_read | d_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_rdata   <= '0;
      if_rdata  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (d_op) begin
            // A simultaneous read and write is treated as a store.
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (if_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        D_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end
        F_BUSY: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_op)        state_next = D_BUSY;
        else if (if_req) state_next = F_BUSY;
      end
      D_BUSY:  if (mem_ack) state_next = D_DONE;
      F_BUSY:  if (mem_ack) state_next = F_DONE;
      // The EX/WB register still shows the finished request here, so no re-sample.
      D_DONE:  state_next = IDLE;
      F_DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign d_done     = (state == D_DONE);
  assign if_valid   = (state == F_DONE);
  assign stall_pipe = d_op && (state != D_DONE);
  assign stall_if   = stall_pipe || (if_req && (state != F_DONE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        stall_pipe;
  logic        stall_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checkCount = 0;
  int failCount  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .stall_pipe(stall_pipe), .stall_if(stall_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] da,
                               input logic [31:0] wd, input logic fr, input logic [31:0] fa,
                               input logic ack, input logic [31:0] rdat);
    d_read    = rd;
    d_write   = wr;
    d_addr    = da;
    d_wdata   = wd;
    if_req    = fr;
    if_addr   = fa;
    mem_ack   = ack;
    mem_rdata = rdat;
    #1;
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1, 0, 32'h100, 32'h0, 1, 32'h300, 0, 32'h0);
    tick();
    tick();
    $display("[TB] reset");
    checkOutput("rst_mem_req",   32'(mem_req),   32'd0);
    checkOutput("rst_mem_we",    32'(mem_we),    32'd0);
    checkOutput("rst_mem_addr",  mem_addr,       32'd0);
    checkOutput("rst_mem_wdata", mem_wdata,      32'd0);
    checkOutput("rst_d_rdata",   d_rdata,        32'd0);
    checkOutput("rst_if_rdata",  if_rdata,       32'd0);
    checkOutput("rst_d_done",    32'(d_done),    32'd0);
    checkOutput("rst_if_valid",  32'(if_valid),  32'd0);
    checkOutput("rst_stall_pipe",32'(stall_pipe),32'd1);
    checkOutput("rst_stall_if",  32'(stall_if),  32'd1);
    rst = 1'b1;
    tick();
    checkOutput("rel_mem_req",  32'(mem_req), 32'd1);
    checkOutput("rel_mem_we",   32'(mem_we),  32'd0);
    checkOutput("rel_mem_addr", mem_addr,     32'h100);
    applyStimulus(1, 0, 32'h100, 32'h0, 1, 32'h300, 1, 32'h55);
    tick();
    checkOutput("rel_d_done",  32'(d_done), 32'd1);
    checkOutput("rel_d_rdata", d_rdata,     32'h55);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();

    $display("[TB] single load");
    applyStimulus(1, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("ld_stall_idle", 32'(stall_pipe), 32'd1);
    checkOutput("ld_req_idle",   32'(mem_req),    32'd0);
    tick();
    checkOutput("ld_req",        32'(mem_req),    32'd1);
    checkOutput("ld_addr",       mem_addr,        32'h40);
    checkOutput("ld_we",         32'(mem_we),     32'd0);
    checkOutput("ld_stall_busy", 32'(stall_pipe), 32'd1);
    applyStimulus(1, 0, 32'h40, 32'h0, 0, 32'h0, 1, 32'hDEADBEEF);
    tick();
    checkOutput("ld_done",       32'(d_done),     32'd1);
    checkOutput("ld_rdata",      d_rdata,         32'hDEADBEEF);
    checkOutput("ld_stall_done", 32'(stall_pipe), 32'd0);
    checkOutput("ld_req_drop",   32'(mem_req),    32'd0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    checkOutput("ld_done_once",  32'(d_done),  32'd0);
    checkOutput("ld_no_reissue", 32'(mem_req), 32'd0);

    $display("[TB] store with wait states");
    applyStimulus(0, 1, 32'h80, 32'h12345678, 0, 32'h0, 0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("st_req_%0d", i),   32'(mem_req), 32'd1);
      checkOutput($sformatf("st_we_%0d", i),    32'(mem_we),  32'd1);
      checkOutput($sformatf("st_wdata_%0d", i), mem_wdata,    32'h12345678);
      checkOutput($sformatf("st_addr_%0d", i),  mem_addr,     32'h80);
      checkOutput($sformatf("st_nodone_%0d", i),32'(d_done),  32'd0);
      if (i == 3) applyStimulus(0, 1, 32'h80, 32'h12345678, 0, 32'h0, 1, 32'hFFFFFFFF);
      tick();
    end
    checkOutput("st_done",  32'(d_done), 32'd1);
    checkOutput("st_rdata", d_rdata,     32'hDEADBEEF);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();

    $display("[TB] contention");
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h200, 0, 32'h0);
    checkOutput("ct_stall_if_idle", 32'(stall_if), 32'd1);
    tick();
    checkOutput("ct_freq",      32'(mem_req),    32'd1);
    checkOutput("ct_faddr",     mem_addr,        32'h200);
    checkOutput("ct_fwe",       32'(mem_we),     32'd0);
    checkOutput("ct_pipe_lo",   32'(stall_pipe), 32'd0);
    applyStimulus(1, 0, 32'h44, 32'h0, 1, 32'h200, 0, 32'h0);
    checkOutput("ct_pipe_hi",   32'(stall_pipe), 32'd1);
    checkOutput("ct_if_hi0",    32'(stall_if),   32'd1);
    tick();
    checkOutput("ct_no_preempt", mem_addr,       32'h200);
    checkOutput("ct_if_hi1",    32'(stall_if),   32'd1);
    applyStimulus(1, 0, 32'h44, 32'h0, 1, 32'h200, 1, 32'hCAFE0001);
    tick();
    checkOutput("ct_if_valid",  32'(if_valid),   32'd1);
    checkOutput("ct_if_rdata",  if_rdata,        32'hCAFE0001);
    checkOutput("ct_no_ddone",  32'(d_done),     32'd0);
    checkOutput("ct_if_hi2",    32'(stall_if),   32'd1);
    applyStimulus(1, 0, 32'h44, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    checkOutput("ct_turn_req",  32'(mem_req),    32'd0);
    checkOutput("ct_turn_val",  32'(if_valid),   32'd0);
    checkOutput("ct_if_hi3",    32'(stall_if),   32'd1);
    tick();
    checkOutput("ct_dreq",      32'(mem_req),    32'd1);
    checkOutput("ct_daddr",     mem_addr,        32'h44);
    checkOutput("ct_if_hi4",    32'(stall_if),   32'd1);
    applyStimulus(1, 0, 32'h44, 32'h0, 0, 32'h0, 1, 32'h0BADF00D);
    tick();
    checkOutput("ct_ddone",     32'(d_done),     32'd1);
    checkOutput("ct_drdata",    d_rdata,         32'h0BADF00D);
    checkOutput("ct_if_hold",   if_rdata,        32'hCAFE0001);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();

    $display("[TB] read and write together");
    applyStimulus(1, 1, 32'h88, 32'hA5A5A5A5, 0, 32'h0, 0, 32'h0);
    tick();
    checkOutput("rw_we",    32'(mem_we), 32'd1);
    checkOutput("rw_wdata", mem_wdata,   32'hA5A5A5A5);
    applyStimulus(1, 1, 32'h88, 32'hA5A5A5A5, 0, 32'h0, 1, 32'h77777777);
    tick();
    checkOutput("rw_done",  32'(d_done), 32'd1);
    checkOutput("rw_rdata", d_rdata,     32'h0BADF00D);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();

    $display("[TB] reset during data access");
    applyStimulus(1, 0, 32'h90, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    checkOutput("mr_req_busy", 32'(mem_req), 32'd1);
    rst = 1'b0;
    tick();
    checkOutput("mr_req_drop", 32'(mem_req), 32'd0);
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h11111111);
    tick();
    checkOutput("mr_no_done",  32'(d_done),  32'd0);
    checkOutput("mr_req_lo",   32'(mem_req), 32'd0);
    checkOutput("mr_rdata",    d_rdata,      32'd0);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h400, 0, 32'h0);
    tick();
    checkOutput("mr_no_done2", 32'(d_done),  32'd0);
    checkOutput("mr_idle_req", 32'(mem_req), 32'd1);
    checkOutput("mr_idle_addr",mem_addr,     32'h400);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h400, 1, 32'h22222222);
    tick();
    checkOutput("mr_f_valid",  32'(if_valid), 32'd1);
    checkOutput("mr_f_rdata",  if_rdata,      32'h22222222);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
